// File: rtl/gauss3x3_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | gauss3x3_stream_if : href/vsync/pixel bundle for the 3x3 smoothing stage |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gauss3x3_stream_if #(
    parameter int DATA_W = 8
);
    logic              href;
    logic              vsync;
    logic [DATA_W-1:0] data;

    modport master (output href, output vsync, output data);
    modport slave  (input  href, input  vsync, input  data);
endinterface
`default_nettype wire

// File: rtl/gauss3x3_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | gauss3x3_stream : streaming 3x3 Gaussian smoothing, 3-cycle latency      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gauss3x3_stream #(
    parameter int IMG_WIDTH = 800,
    parameter int DATA_W    = 8,
    parameter int X_W       = 11
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    gauss3x3_stream_if.slave   i_pix,
    gauss3x3_stream_if.master  o_pix
);

    localparam int              c_AW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int              c_RS_W  = DATA_W + 2;
    localparam int              c_SUM_W = DATA_W + 4;
    localparam logic [X_W-1:0]  c_X_MAX = X_W'(IMG_WIDTH);
    localparam logic [X_W-1:0]  c_Y_MAX = '1;
    localparam logic [X_W-1:0]  c_TWO   = X_W'(2);
    localparam logic [c_SUM_W-1:0] c_RND = c_SUM_W'(8);

    logic [X_W-1:0]    r_x;
    logic [X_W-1:0]    r_y;
    logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] r_win [3][3];

    logic              r_href1, r_href2, r_href3;
    logic              r_vs1,   r_vs2,   r_vs3;
    logic              r_msk1,  r_msk2;
    logic [c_RS_W-1:0] r_rs0, r_rs1, r_rs2;
    logic [DATA_W-1:0] r_data3;

    logic              w_wr;
    logic [c_AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_lb1_q;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_mid;
    logic [c_SUM_W-1:0] w_sum;
    logic [DATA_W-1:0] w_res;

    // Overrun pixels (x >= IMG_WIDTH) neither touch the buffers nor shift the window.
    assign w_wr    = i_pix.href && (r_x < c_X_MAX);
    assign w_addr  = r_x[c_AW-1:0];
    assign w_lb1_q = r_lb1[w_addr];
    assign w_mid   = w_wr ? w_lb1_q : '0;
    assign w_top   = w_wr ? r_lb2[w_addr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_lb1[w_addr] <= i_pix.data;
            r_lb2[w_addr] <= w_lb1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (!i_pix.href)
                r_x <= '0;
            else if (r_x != c_X_MAX)
                r_x <= r_x + X_W'(1);

            // vsync low wins over a simultaneous href falling edge.
            if (!i_pix.vsync)
                r_y <= '0;
            else if (r_href1 && !i_pix.href && (r_y != c_Y_MAX))
                r_y <= r_y + X_W'(1);
        end
    end

    // S1: window shift; rows are top = y-2, mid = y-1, bottom = y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_href1 <= 1'b0;
            r_vs1   <= 1'b0;
            r_msk1  <= 1'b1;
        end else begin
            if (w_wr) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_top;
                r_win[1][2] <= w_mid;
                r_win[2][2] <= i_pix.data;
            end
            r_href1 <= i_pix.href;
            r_vs1   <= i_pix.vsync;
            r_msk1  <= (r_x < c_TWO) || (r_y < c_TWO) || !w_wr;
        end
    end

    // S2: weighted row sums [1 2 1], row weights applied in S3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs0   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_href2 <= 1'b0;
            r_vs2   <= 1'b0;
            r_msk2  <= 1'b1;
        end else begin
            r_rs0   <= {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
            r_rs1   <= {2'b00, r_win[1][0]} + {1'b0, r_win[1][1], 1'b0} + {2'b00, r_win[1][2]};
            r_rs2   <= {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
            r_href2 <= r_href1;
            r_vs2   <= r_vs1;
            r_msk2  <= r_msk1;
        end
    end

    // Full-scale sum is 16*(2^DATA_W-1), so the rounded result always fits.
    assign w_sum = {2'b00, r_rs0} + {1'b0, r_rs1, 1'b0} + {2'b00, r_rs2};
    assign w_res = DATA_W'((w_sum + c_RND) >> 4);

    // S3: round, border mask, output framing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_href3 <= 1'b0;
            r_vs3   <= 1'b0;
            r_data3 <= '0;
        end else begin
            r_href3 <= r_href2;
            r_vs3   <= r_vs2;
            r_data3 <= (r_href2 && !r_msk2) ? w_res : '0;
        end
    end

    assign o_pix.href  = r_href3;
    assign o_pix.vsync = r_vs3;
    assign o_pix.data  = r_data3;

endmodule
`default_nettype wire

// File: tb/tb_gauss3x3_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gauss3x3_stream : directed frames against hand-derived pixel values   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gauss3x3_stream;

    localparam int W    = 16;
    localparam int HB   = 4;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst_n;

    gauss3x3_stream_if #(.DATA_W(8)) in_if ();
    gauss3x3_stream_if #(.DATA_W(8)) out_if ();

    gauss3x3_stream #(.IMG_WIDTH(W), .DATA_W(8), .X_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_pix (in_if),
        .o_pix (out_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int ncyc = 0;

    logic       ih_log [LOGN];
    logic       iv_log [LOGN];
    logic       oh_log [LOGN];
    logic       ov_log [LOGN];
    logic [7:0] od_log [LOGN];
    int         ix_log [LOGN];
    int         iy_log [LOGN];

    // Outputs sampled at slot n reflect the inputs driven at slot n-3.
    task automatic tick(input logic h, input logic v, input logic [7:0] d,
                        input logic r, input int x, input int y);
        @(negedge clk);
        if (ncyc < LOGN) begin
            oh_log[ncyc] = out_if.href;
            ov_log[ncyc] = out_if.vsync;
            od_log[ncyc] = out_if.data;
        end
        in_if.href  = h;
        in_if.vsync = v;
        in_if.data  = d;
        rst_n       = r;
        if (ncyc < LOGN) begin
            ih_log[ncyc] = h;
            iv_log[ncyc] = v;
            ix_log[ncyc] = x;
            iy_log[ncyc] = y;
            ncyc++;
        end
    endtask

    // pat 0: flat val (overrun pixels carry 7); pat 1: val at (10,10), else 0.
    task automatic send_frame(input int pat, input logic [7:0] val, input int nlines,
                              input int vbl, input int extra);
        logic [7:0] p;
        for (int l = 0; l < vbl; l++)
            for (int k = 0; k < W + extra + HB; k++)
                tick(1'b0, 1'b0, 8'd0, 1'b1, -1, -1);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < W + extra; x++) begin
                if (pat == 0) p = (x < W) ? val : 8'd7;
                else          p = (x == 10 && y == 10) ? val : 8'd0;
                tick(1'b1, 1'b1, p, 1'b1, x, y);
            end
            for (int k = 0; k < HB; k++)
                tick(1'b0, 1'b1, 8'd0, 1'b1, -1, -1);
        end
        for (int k = 0; k < 4; k++)
            tick(1'b0, 1'b1, 8'd0, 1'b1, -1, -1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++)
            tick(1'b1, 1'b1, 8'd99, 1'b0, -1, -1);
        tick(1'b0, 1'b0, 8'd0, 1'b1, -1, -1);
        for (int c = 1; c <= 3; c++) begin
            n_chk++;
            if (oh_log[c] !== 1'b0 || ov_log[c] !== 1'b0 || od_log[c] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset slot=%0d got href=%b vsync=%b data=%0d expected 0/0/0",
                         c, oh_log[c], ov_log[c], od_log[c]);
            end
        end
    endtask

    task automatic test_flat(input logic [7:0] val);
        int s;
        logic [7:0] e;
        s = ncyc;
        send_frame(0, val, 8, 2, 0);
        for (int c = s; c + 3 < ncyc; c++) begin
            e = (ih_log[c] && ix_log[c] >= 2 && iy_log[c] >= 2) ? val : 8'd0;
            n_chk++;
            if (oh_log[c+3] !== ih_log[c] || ov_log[c+3] !== iv_log[c]) begin
                n_fail++;
                $display("FAIL flat_framing v=%0d slot=%0d got href=%b vsync=%b expected %b/%b",
                         val, c, oh_log[c+3], ov_log[c+3], ih_log[c], iv_log[c]);
            end
            n_chk++;
            if (od_log[c+3] !== e) begin
                n_fail++;
                $display("FAIL flat_data v=%0d x=%0d y=%0d got %0d expected %0d",
                         val, ix_log[c], iy_log[c], od_log[c+3], e);
            end
        end
    endtask

    task automatic test_impulse();
        int s, x, y;
        logic [7:0] e;
        s = ncyc;
        send_frame(1, 8'd160, 14, 2, 0);
        for (int c = s; c + 3 < ncyc; c++) begin
            x = ix_log[c];
            y = iy_log[c];
            e = 8'd0;
            if (x == 11 && y == 11)
                e = 8'd40;
            else if (((x == 10 || x == 12) && y == 11) || (x == 11 && (y == 10 || y == 12)))
                e = 8'd20;
            else if ((x == 10 || x == 12) && (y == 10 || y == 12))
                e = 8'd10;
            n_chk++;
            if (oh_log[c+3] !== ih_log[c] || od_log[c+3] !== e) begin
                n_fail++;
                $display("FAIL impulse x=%0d y=%0d got href=%b data=%0d expected %b/%0d",
                         x, y, oh_log[c+3], od_log[c+3], ih_log[c], e);
            end
        end
    endtask

    task automatic test_overrun();
        int s;
        logic [7:0] e;
        s = ncyc;
        send_frame(0, 8'd100, 8, 2, 4);
        for (int c = s; c + 3 < ncyc; c++) begin
            e = (ih_log[c] && ix_log[c] >= 2 && ix_log[c] < W && iy_log[c] >= 2) ? 8'd100 : 8'd0;
            n_chk++;
            if (oh_log[c+3] !== ih_log[c] || od_log[c+3] !== e) begin
                n_fail++;
                $display("FAIL overrun x=%0d y=%0d got href=%b data=%0d expected %b/%0d",
                         ix_log[c], iy_log[c], oh_log[c+3], od_log[c+3], ih_log[c], e);
            end
        end
    endtask

    task automatic test_reset_midline();
        int r0, s;
        logic [7:0] e;
        for (int k = 0; k < 2 * (W + HB); k++)
            tick(1'b0, 1'b0, 8'd0, 1'b1, -1, -1);
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < ((y < 4) ? W : 5); x++)
                tick(1'b1, 1'b1, 8'd100, 1'b1, x, y);
            if (y < 4)
                for (int k = 0; k < HB; k++)
                    tick(1'b0, 1'b1, 8'd0, 1'b1, -1, -1);
        end
        r0 = ncyc;
        tick(1'b1, 1'b1, 8'd100, 1'b0, -1, -1);
        tick(1'b1, 1'b1, 8'd100, 1'b0, -1, -1);
        for (int k = 0; k < 3; k++)
            tick(1'b0, 1'b1, 8'd0, 1'b1, -1, -1);
        for (int c = r0 + 1; c <= r0 + 2; c++) begin
            n_chk++;
            if (oh_log[c] !== 1'b0 || ov_log[c] !== 1'b0 || od_log[c] !== 8'd0) begin
                n_fail++;
                $display("FAIL midline_reset slot=%0d got href=%b vsync=%b data=%0d expected 0/0/0",
                         c, oh_log[c], ov_log[c], od_log[c]);
            end
        end
        s = ncyc;
        send_frame(0, 8'd100, 8, 2, 0);
        for (int c = s; c + 3 < ncyc; c++) begin
            e = (ih_log[c] && ix_log[c] >= 2 && iy_log[c] >= 2) ? 8'd100 : 8'd0;
            n_chk++;
            if (oh_log[c+3] !== ih_log[c] || ov_log[c+3] !== iv_log[c] || od_log[c+3] !== e) begin
                n_fail++;
                $display("FAIL post_reset x=%0d y=%0d got %b/%b/%0d expected %b/%b/%0d",
                         ix_log[c], iy_log[c], oh_log[c+3], ov_log[c+3], od_log[c+3],
                         ih_log[c], iv_log[c], e);
            end
        end
    endtask

    task automatic test_early_vsync();
        int s1, s2;
        logic [7:0] e;
        s1 = ncyc;
        send_frame(0, 8'd60, 3, 2, 0);
        s2 = ncyc;
        send_frame(0, 8'd200, 4, 2, 0);
        for (int c = s1; c + 3 < ncyc; c++) begin
            e = 8'd0;
            if (ih_log[c] && ix_log[c] >= 2 && iy_log[c] >= 2)
                e = (c < s2) ? 8'd60 : 8'd200;
            n_chk++;
            if (oh_log[c+3] !== ih_log[c] || od_log[c+3] !== e) begin
                n_fail++;
                $display("FAIL early_vsync x=%0d y=%0d got href=%b data=%0d expected %b/%0d",
                         ix_log[c], iy_log[c], oh_log[c+3], od_log[c+3], ih_log[c], e);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_if.href  = 1'b0;
        in_if.vsync = 1'b0;
        in_if.data  = 8'd0;
        test_reset();
        test_flat(8'd100);
        test_impulse();
        test_flat(8'd255);
        test_overrun();
        test_reset_midline();
        test_early_vsync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
